// File: rtl/alu_slice_exec.sv
// alu_slice_exec: multi-cycle sliced ALU execute unit with start/busy/done handshake
module alu_slice_exec #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             invA,
    input  logic             invB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out,
    output logic             Cout,
    output logic             Ofl,
    output logic             Zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, out_q, out_d;
    logic [1:0]       op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d, done_q, done_d;
    logic             cout_q, cout_d, ofl_q, ofl_d, zero_q, zero_d;
    logic [SLICE-1:0] a_sl, b_sl, r_sl;
    logic [SLICE:0]   sum;
    logic             last;

    // Slice datapath: one SLICE-wide chunk of the latched operands per cycle
    always_comb begin
        a_sl = a_q[k_q*SLICE +: SLICE];
        b_sl = b_q[k_q*SLICE +: SLICE];
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        r_sl = (op_q == OP_ADD) ? sum[SLICE-1:0] :
               (op_q == OP_OR)  ? (a_sl | b_sl)  :
               (op_q == OP_XOR) ? (a_sl ^ b_sl)  : (a_sl & b_sl);
        last = (state_q == RUN) && (k_q == KW'(N - 1));
    end

    // Control and next state: accept in IDLE, build the result slice by slice in RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        k_d     = k_q;
        part_d  = part_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ofl_d   = ofl_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                a_d     = invA ? ~A : A;
                b_d     = invB ? ~B : B;
                op_d    = op;
                carry_d = Cin;
                k_d     = '0;
            end
        end else begin
            part_d[k_q*SLICE +: SLICE] = r_sl;
            carry_d = sum[SLICE];
            k_d     = k_q + KW'(1);
            if (last) begin
                // Visible outputs update only here, so they never show a half-built result
                state_d = IDLE;
                k_d     = '0;
                done_d  = 1'b1;
                out_d   = part_d;
                cout_d  = (op_q == OP_ADD) && sum[SLICE];
                ofl_d   = (op_q == OP_ADD) && (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (part_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_d  = (part_d == '0);
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            part_q  <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ofl_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            part_q  <= part_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ofl_q   <= ofl_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign Out  = out_q;
    assign Cout = cout_q;
    assign Ofl  = ofl_q;
    assign Zero = zero_q;
endmodule

// File: tb/tb_alu_slice_exec.sv
// tb_alu_slice_exec: directed-vector self-checking bench for alu_slice_exec
module tb_alu_slice_exec;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] A = '0, B = '0;
    logic        Cin = 1'b0, invA = 1'b0, invB = 1'b0;
    logic        busy, done, Cout, Ofl, Zero;
    logic [15:0] Out;
    int          n_vec = 0;
    int          n_err = 0;

    alu_slice_exec #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .Cin(Cin), .invA(invA), .invB(invB), .busy(busy), .done(done),
        .Out(Out), .Cout(Cout), .Ofl(Ofl), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present a request at the negedge, let E0 accept it, then scramble the inputs
    task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic ia, input logic ib);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; Cin = ci; invA = ia; invB = ib;
        @(posedge clk);
        #1;
        start = 1'b0; A = 16'h5A5A; B = 16'hA5A5; op = 2'b11; Cin = 1'b1; invA = 1'b1; invB = 1'b1;
        check("busy_after_accept", busy, 1);
        check("done_after_accept", done, 0);
    endtask

    // Count edges until done, bounded, and require it exactly 4 edges after accept
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic result(input string tag, input logic [15:0] eo, input logic ec,
                          input logic ev, input logic ez);
        check({tag, "_Out"}, Out, eo);
        check({tag, "_Cout"}, Cout, ec);
        check({tag, "_Ofl"}, Ofl, ev);
        check({tag, "_Zero"}, Zero, ez);
    endtask

    task automatic full_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                           input logic [15:0] b, input logic ci, input logic ia, input logic ib,
                           input logic [15:0] eo, input logic ec, input logic ev, input logic ez);
        launch(o, a, b, ci, ia, ib);
        wait_done(tag);
        result(tag, eo, ec, ev, ez);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        bit seen;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        result("rst", 16'h0000, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        full_op("add", 2'b00, 16'h1234, 16'h0001, 0, 0, 0, 16'h1235, 0, 0, 0);
        full_op("sub", 2'b00, 16'h0005, 16'h0005, 1, 0, 1, 16'h0000, 1, 0, 1);
        full_op("ofl", 2'b00, 16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1, 0);
        full_op("wrap", 2'b00, 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 1);
        full_op("cin", 2'b00, 16'h00FF, 16'h0001, 1, 0, 0, 16'h0101, 0, 0, 0);
        full_op("xor", 2'b10, 16'hFFFF, 16'h0F0F, 0, 0, 0, 16'hF0F0, 0, 0, 0);
        full_op("andia", 2'b11, 16'h00FF, 16'hFFFF, 0, 1, 0, 16'hFF00, 0, 0, 0);
        full_op("or", 2'b01, 16'h1200, 16'h0034, 1, 0, 0, 16'h1234, 0, 0, 0);
        full_op("xorz", 2'b10, 16'hAAAA, 16'hAAAA, 1, 0, 0, 16'h0000, 0, 0, 1);

        // start held through E1..E3 with other operands must be ignored, Out held mid-run
        launch(2'b00, 16'h1234, 16'h0001, 0, 0, 0);
        start = 1'b1; op = 2'b01; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; invA = 1'b0; invB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("ign_busy", busy, 1);
            check("ign_out_held", Out, 16'h0000);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("ign_done", done, 1);
        result("ign", 16'h1235, 0, 0, 0);

        // start in the done cycle is accepted
        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 16'h0010; B = 16'h0020; Cin = 1'b0; invA = 1'b0; invB = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        wait_done("b2b");
        result("b2b", 16'h0030, 0, 0, 0);

        // async reset at E2 of an ADD aborts with no done pulse
        launch(2'b00, 16'h1111, 16'h2222, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_Out", Out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        full_op("post", 2'b00, 16'h0002, 16'h0003, 0, 0, 0, 16'h0005, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
